// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        int  j;
        logic hit;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j        = (int'(ptr) + i) % NUM_REQ;
            hit      = !valid && req[j];
            valid    = valid | hit;
            idx      = hit ? IDX_W'(j) : idx;
            grant[j] = hit;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin owner of a single SPI master shared by NUM_REQ clients, multi-frame transactions.
// Optional frame watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = 4,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*LEN_W-1:0]  len_i,
    input  logic [NUM_REQ*BYTE_W-1:0] tx_data_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic [NUM_REQ-1:0]        byte_ack_o,
    output logic [NUM_REQ-1:0]        rx_valid_o,
    output logic [BYTE_W-1:0]         rx_data_o,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      m_start_o,
    output logic [BYTE_W-1:0]         m_tx_data_o,
    input  logic [BYTE_W-1:0]         m_rx_data_i,
    input  logic                      m_done_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     idx_r;
    logic [LEN_W-1:0]     cnt_r;
    logic [GAP_W-1:0]     gap_r;
    logic [WD_W-1:0]      wd_r;
    logic [NUM_REQ-1:0]   arb_grant_s;
    logic [IDX_W-1:0]     arb_idx_s;
    logic                 arb_valid_s;
    logic [LEN_W-1:0]     len_sel_s;
    logic [BYTE_W-1:0]    tx_sel_s;
    logic                 done_s;
    logic                 timeout_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_i),
        .ptr   (ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    assign len_sel_s = len_i[int'(arb_idx_s)*LEN_W +: LEN_W];
    assign tx_sel_s  = tx_data_i[int'(idx_r)*BYTE_W +: BYTE_W];
    // A done pulse landing on the start-pulse cycle cannot belong to this frame.
    assign done_s    = m_done_i && !m_start_o;
    assign timeout_s = WD_EN && (state_r == WAIT) && !done_s && (wd_r == WD_LIMIT);

    // Next-state decode for the transaction sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = (|req_i) ? ARB : IDLE;
            ARB:     state_s = arb_valid_s ? START : IDLE;
            START:   state_s = WAIT;
            WAIT: begin
                if (done_s) begin
                    state_s = (cnt_r == LEN_W'(1)) ? GAP : START;
                end else if (timeout_s) begin
                    state_s = GAP;
                end else begin
                    state_s = WAIT;
                end
            end
            GAP:     state_s = (gap_r == GAP_LAST) ? IDLE : GAP;
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state, grant/pointer bookkeeping and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            idx_r       <= '0;
            cnt_r       <= '0;
            gap_r       <= '0;
            wd_r        <= '0;
            grant_o     <= '0;
            byte_ack_o  <= '0;
            rx_valid_o  <= '0;
            rx_data_o   <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            m_start_o   <= 1'b0;
            m_tx_data_o <= '0;
        end else begin
            state_r    <= state_s;
            busy_o     <= (state_s != IDLE);
            err_o      <= err_o | timeout_s;
            m_start_o  <= 1'b0;
            byte_ack_o <= '0;
            rx_valid_o <= '0;
            case (state_r)
                ARB: begin
                    grant_o <= arb_grant_s;
                    idx_r   <= arb_idx_s;
                    cnt_r   <= (len_sel_s == '0) ? LEN_W'(1) : len_sel_s;
                    if (arb_valid_s) begin
                        ptr_r <= (arb_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx_s + IDX_W'(1);
                    end else begin
                        ptr_r <= ptr_r;
                    end
                end
                START: begin
                    m_start_o   <= 1'b1;
                    m_tx_data_o <= tx_sel_s;
                    byte_ack_o  <= grant_o;
                    wd_r        <= '0;
                end
                WAIT: begin
                    gap_r <= '0;
                    if (done_s) begin
                        rx_data_o  <= m_rx_data_i;
                        rx_valid_o <= grant_o;
                        cnt_r      <= cnt_r - LEN_W'(1);
                        wd_r       <= '0;
                    end else begin
                        wd_r <= WD_EN ? wd_r + WD_W'(1) : '0;
                    end
                end
                GAP: begin
                    if (state_s == IDLE) begin
                        grant_o <= '0;
                    end else begin
                        gap_r <= gap_r + GAP_W'(1);
                    end
                end
                default: begin
                    gap_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: vector table plus hand sequences, scoreboard queues.
`timescale 1ns/1ps
module tb_spi_arbiter;
    import spi_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int LEN_W   = 4;
    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_i;
    logic [11:0] len_i;
    logic [23:0] tx_data_i;
    logic [2:0]  grant_o, byte_ack_o, rx_valid_o;
    logic [7:0]  rx_data_o, m_tx_data_o, m_rx_data_i;
    logic        busy_o, err_o, m_start_o, m_done_i;

    always #5 clk = ~clk;

    spi_arbiter #(.NUM_REQ(NUM_REQ), .LEN_W(LEN_W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .len_i(len_i), .tx_data_i(tx_data_i),
        .grant_o(grant_o), .byte_ack_o(byte_ack_o), .rx_valid_o(rx_valid_o),
        .rx_data_o(rx_data_o), .busy_o(busy_o), .err_o(err_o), .m_start_o(m_start_o),
        .m_tx_data_o(m_tx_data_o), .m_rx_data_i(m_rx_data_i), .m_done_i(m_done_i)
    );

    typedef struct { logic [2:0] oh; logic [7:0] data; } exp_t;
    typedef struct {
        logic [2:0] req; logic [3:0] len;
        logic [7:0] b0; logic [7:0] b1; logic [7:0] b2;
        logic [2:0] grant; int frames;
    } row_t;

    exp_t start_q[$];
    exp_t rx_q[$];
    int checks = 0, failures = 0;
    int cyc = 0, start_cnt = 0, rx_cnt = 0, last_rx_cyc = 0, last_start_cyc = 0;
    int ack_cnt[3] = '{0, 0, 0};
    int ack_base[3] = '{0, 0, 0};
    logic [7:0] cl_bytes[3][4];
    int master_dly = 2;
    bit master_en  = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_bytes(input int k, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        cl_bytes[k][0] = b0; cl_bytes[k][1] = b1; cl_bytes[k][2] = b2; cl_bytes[k][3] = b3;
        ack_base[k] = ack_cnt[k];
    endtask

    task automatic expect_frame(input logic [2:0] oh, input logic [7:0] tx, input bit with_rx);
        start_q.push_back('{oh, tx});
        if (with_rx) rx_q.push_back('{oh, ~tx});
    endtask

    task automatic wait_grant(input int bound);
        for (int n = 0; n < bound && grant_o == 3'b000; n++) tick();
    endtask

    task automatic wait_idle(input int bound);
        for (int n = 0; n < bound && busy_o; n++) tick();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Client model: each client advances to its next byte on byte_ack.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (byte_ack_o[k]) ack_cnt[k] <= ack_cnt[k] + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            tx_data_i[k*8 +: 8] = cl_bytes[k][(ack_cnt[k] - ack_base[k]) & 3];
        end
    end

    // SPI master model: answers each start with ~tx after master_dly cycles.
    initial begin
        logic [7:0] t;
        m_done_i = 1'b0;
        m_rx_data_i = 8'h00;
        forever begin
            @(negedge clk);
            if (m_start_o && master_en) begin
                t = m_tx_data_o;
                repeat (master_dly) @(negedge clk);
                m_rx_data_i = ~t;
                m_done_i = 1'b1;
                @(negedge clk);
                m_done_i = 1'b0;
            end
        end
    end

    // Scoreboard: compare each start and each rx pulse against the expected queues.
    always @(negedge clk) begin
        if (!rst && m_start_o) begin
            start_cnt <= start_cnt + 1;
            last_start_cyc <= cyc;
            check("start_expected", 32'(start_q.size() != 0), 32'd1);
            if (start_q.size() != 0) begin
                check("start_tx", m_tx_data_o, start_q[0].data);
                check("start_ack", byte_ack_o, start_q[0].oh);
                check("start_grant", grant_o, start_q[0].oh);
                void'(start_q.pop_front());
            end
        end
        if (!rst && rx_valid_o != 3'b000) begin
            rx_cnt <= rx_cnt + 1;
            last_rx_cyc <= cyc;
            check("rx_expected", 32'(rx_q.size() != 0), 32'd1);
            if (rx_q.size() != 0) begin
                check("rx_valid", rx_valid_o, rx_q[0].oh);
                check("rx_data", rx_data_o, rx_q[0].data);
                check("rx_grant_held", grant_o, rx_q[0].oh);
                void'(rx_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=hang required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        row_t rows[6];
        logic [7:0] bb[3];
        logic [2:0] rr_exp[4];
        int k, base;

        rows[0] = '{3'b001, 4'd3, 8'hAA, 8'h55, 8'h5D, 3'b001, 3};
        rows[1] = '{3'b011, 4'd1, 8'h3C, 8'h00, 8'h00, 3'b010, 1};
        rows[2] = '{3'b010, 4'd0, 8'h81, 8'h00, 8'h00, 3'b010, 1};
        rows[3] = '{3'b101, 4'd2, 8'hF0, 8'h0F, 8'h00, 3'b100, 2};
        rows[4] = '{3'b110, 4'd1, 8'h96, 8'h00, 8'h00, 3'b010, 1};
        rows[5] = '{3'b011, 4'd2, 8'h12, 8'hED, 8'h00, 3'b001, 2};

        rst = 1'b1; req_i = 3'b000; len_i = '0;
        for (int c = 0; c < 3; c++) set_bytes(c, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        check("rst_grant", grant_o, 3'b000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_start", m_start_o, 1'b0);
        check("rst_ack", byte_ack_o, 3'b000);
        check("rst_rxv", rx_valid_o, 3'b000);
        check("rst_rxd", rx_data_o, 8'h00);
        check("rst_mtx", m_tx_data_o, 8'h00);
        rst = 1'b0;
        tick();

        // Table: single transactions, round-robin pointer carried row to row.
        for (int r = 0; r < 6; r++) begin
            bb = '{rows[r].b0, rows[r].b1, rows[r].b2};
            for (int c = 0; c < 3; c++) set_bytes(c, bb[0], bb[1], bb[2], 8'h00);
            len_i = {3{rows[r].len}};
            for (int f = 0; f < rows[r].frames; f++) expect_frame(rows[r].grant, bb[f], 1'b1);
            req_i = rows[r].req;
            wait_grant(20);
            check("row_grant", grant_o, rows[r].grant);
            req_i = 3'b000;
            wait_idle(500);
            check("row_idle", busy_o, 1'b0);
            check("row_gap_len", cyc - last_rx_cyc, GAP_CYC);
            check("row_grant_clear", grant_o, 3'b000);
            check("row_pending", start_q.size() + rx_q.size(), 0);
        end

        // All three requesting continuously: strict rotation with a gap between owners.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        for (int c = 0; c < 3; c++) set_bytes(c, 8'hC0 + 8'(c), 8'hC0 + 8'(c), 8'hC0 + 8'(c), 8'hC0 + 8'(c));
        len_i = {3{4'd1}};
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int g = 0; g < 4; g++) expect_frame(rr_exp[g], 8'hC0 + 8'(g % 3), 1'b1);
        req_i = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_grant(200);
            check("rr_order", grant_o, rr_exp[g]);
            if (g == 3) req_i = 3'b000;
            for (int n = 0; n < 200 && grant_o != 3'b000; n++) tick();
            check("rr_gap", grant_o, 3'b000);
        end
        wait_idle(100);
        check("rr_pending", start_q.size() + rx_q.size(), 0);

        // Requester drops after the first frame of two: second frame still issued.
        set_bytes(0, 8'h11, 8'h22, 8'h00, 8'h00);
        len_i = {3{4'd2}};
        expect_frame(3'b001, 8'h11, 1'b1);
        expect_frame(3'b001, 8'h22, 1'b1);
        base = start_cnt;
        k = rx_cnt;
        req_i = 3'b001;
        for (int n = 0; n < 100 && rx_cnt == k; n++) tick();
        req_i = 3'b000;
        wait_idle(200);
        check("drop_starts", start_cnt - base, 2);
        check("drop_pending", start_q.size() + rx_q.size(), 0);

        // Reset while waiting on frame 2 of 3.
        master_dly = 6;
        set_bytes(0, 8'h31, 8'h32, 8'h33, 8'h00);
        len_i = {3{4'd3}};
        expect_frame(3'b001, 8'h31, 1'b1);
        expect_frame(3'b001, 8'h32, 1'b0);
        base = start_cnt;
        req_i = 3'b001;
        for (int n = 0; n < 100 && start_cnt - base < 2; n++) tick();
        req_i = 3'b000;
        tick(); tick();
        check("pre_rst_busy", busy_o, 1'b1);
        rst = 1'b1;
        #1;
        check("async_grant", grant_o, 3'b000);
        check("async_busy", busy_o, 1'b0);
        check("async_start", m_start_o, 1'b0);
        tick(); tick();
        rst = 1'b0;
        base = start_cnt;
        repeat (20) tick();
        check("no_replay", start_cnt - base, 0);
        check("rst_pending", start_q.size() + rx_q.size(), 0);
        master_dly = 2;
        set_bytes(1, 8'h44, 8'h00, 8'h00, 8'h00);
        len_i = {3{4'd1}};
        expect_frame(3'b010, 8'h44, 1'b1);
        req_i = 3'b110;
        wait_grant(20);
        check("post_rst_grant", grant_o, 3'b010);
        req_i = 3'b000;
        wait_idle(100);
        check("post_rst_pending", start_q.size() + rx_q.size(), 0);

        // Master never answers.
        master_en = 1'b0;
        set_bytes(0, 8'h77, 8'h00, 8'h00, 8'h00);
        expect_frame(3'b001, 8'h77, 1'b0);
        req_i = 3'b001;
        wait_grant(20);
        req_i = 3'b000;
`ifdef SPI_ARB_TIMEOUT_EN
        for (int n = 0; n < 300 && !err_o; n++) tick();
        check("wd_err", err_o, 1'b1);
        check("wd_latency", cyc - last_start_cyc, TIMEOUT + 1);
        wait_idle(50);
        check("wd_idle", busy_o, 1'b0);
        check("wd_sticky", err_o, 1'b1);
`else
        repeat (TIMEOUT + 40) tick();
        check("hold_busy", busy_o, 1'b1);
        check("hold_err", err_o, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("hold_rst_busy", busy_o, 1'b0);
`endif
        master_en = 1'b1;
        set_bytes(1, 8'h5A, 8'h00, 8'h00, 8'h00);
        expect_frame(3'b010, 8'h5A, 1'b1);
        req_i = 3'b010;
        wait_grant(20);
        check("after_stall_grant", grant_o, 3'b010);
        req_i = 3'b000;
        wait_idle(100);
        check("final_pending", start_q.size() + rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
